// File: rtl/apb_xfer_sequencer.sv
// Round-robin multi-requester to APB bridge: one transfer in flight, address decode
// over NUM_APB equal windows, and an ACCESS wait-state timeout.
module apb_xfer_sequencer #(
    parameter int          NUM_REQ        = 2,
    parameter int          NUM_APB        = 4,
    parameter logic [31:0] APB_BASE_ADDR  = 32'h8000_0000,
    parameter logic [31:0] APB_ADDR_RANGE = 32'h0000_1000,
    parameter int          TIMEOUT        = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][31:0] req_addr,
    input  logic [NUM_REQ-1:0][31:0] req_wdata,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [NUM_REQ-1:0][2:0]  req_size,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [3:0]               PSTRB,
    output logic [NUM_APB-1:0]       PSEL,
    input  logic [31:0]              PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int          GW      = $clog2(NUM_REQ);
    localparam int          SW      = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;
    localparam logic [32:0] BASE33  = {1'b0, APB_BASE_ADDR};
    localparam logic [32:0] RANGE33 = {1'b0, APB_ADDR_RANGE};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   r_grant;
    logic [SW-1:0]   r_sel;
    logic [7:0]      r_wait;
    logic [31:0]     r_paddr;
    logic [31:0]     r_pwdata;
    logic            r_pwrite;
    logic [3:0]      r_pstrb;
    logic [31:0]     r_rdata;
    logic            r_err;

    logic            w_any;
    logic [GW-1:0]   w_gnt;
    logic            w_hit;
    logic [SW-1:0]   w_sel;
    logic [32:0]     w_addr33;
    logic            w_timeout;

    function automatic logic [3:0] strb_f(input logic wr, input logic [2:0] sz, input logic [1:0] a);
        logic [3:0] s;
        if (!wr) begin
            s = 4'b0000;
        end else begin
            case (sz)
                3'd0:    s = 4'b0001 << a;
                3'd1:    s = 4'b0011 << {a[1], 1'b0};
                default: s = 4'b1111;
            endcase
        end
        return s;
    endfunction

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && req_valid[(int'(r_last_grant) + k) % NUM_REQ]) begin
                w_any = 1'b1;
                w_gnt = GW'((int'(r_last_grant) + k) % NUM_REQ);
            end else begin
                w_any = w_any;
            end
        end
    end

    // Peripheral window decode in 33 bits so the top window cannot wrap
    always_comb begin
        w_hit    = 1'b0;
        w_sel    = '0;
        w_addr33 = {1'b0, req_addr[w_gnt]};
        for (int i = 0; i < NUM_APB; i++) begin
            if (!w_hit && (w_addr33 >= BASE33 + RANGE33 * 33'(i)) &&
                (w_addr33 < BASE33 + RANGE33 * 33'(i + 1))) begin
                w_hit = 1'b1;
                w_sel = SW'(i);
            end else begin
                w_hit = w_hit;
            end
        end
    end

    assign w_timeout = !PREADY && (r_wait == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next = w_hit ? ST_SETUP : ST_RESP;
                       else       w_next = ST_IDLE;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (PREADY || w_timeout) w_next = ST_RESP;
                       else                     w_next = ST_ACCESS;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the registered state; req_ready is the grant itself
    always_comb begin
        PSEL      = '0;
        req_ready = '0;
        rsp_valid = '0;
        if ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) PSEL[r_sel] = 1'b1;
        else                                                  PSEL = '0;
        if ((r_state == ST_IDLE) && !HRESET && w_any) req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_gnt;
        else                                          req_ready = '0;
        if (r_state == ST_RESP) rsp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant;
        else                    rsp_valid = '0;
        PENABLE = (r_state == ST_ACCESS);
    end

    // Transfer datapath: grant capture, APB drive registers, wait counter, response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_last_grant <= GW'(NUM_REQ - 1);
            r_grant      <= '0;
            r_sel        <= '0;
            r_wait       <= 8'd0;
            r_paddr      <= 32'd0;
            r_pwdata     <= 32'd0;
            r_pwrite     <= 1'b0;
            r_pstrb      <= 4'd0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_gnt;
                        r_last_grant <= w_gnt;
                        if (w_hit) begin
                            r_sel    <= w_sel;
                            r_wait   <= 8'd0;
                            r_paddr  <= req_addr[w_gnt];
                            r_pwdata <= req_wdata[w_gnt];
                            r_pwrite <= req_write[w_gnt];
                            r_pstrb  <= strb_f(req_write[w_gnt], req_size[w_gnt], req_addr[w_gnt][1:0]);
                        end else begin
                            r_rdata <= 32'd0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_rdata <= r_pwrite ? 32'd0 : PRDATA;
                        r_err   <= PSLVERR;
                    end else if (w_timeout) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: r_wait <= r_wait;
            endcase
        end
    end

    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign PWRITE    = r_pwrite;
    assign PSTRB     = r_pstrb;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Directed bench for apb_xfer_sequencer with default parameters.
module tb_apb_xfer_sequencer;

    logic             HCLK;
    logic             HRESET;
    logic [1:0]       req_valid;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_write;
    logic [1:0][2:0]  req_size;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic [31:0]      PADDR;
    logic [31:0]      PWDATA;
    logic             PWRITE;
    logic             PENABLE;
    logic [3:0]       PSTRB;
    logic [3:0]       PSEL;
    logic [31:0]      PRDATA;
    logic             PREADY;
    logic             PSLVERR;

    int checks = 0;
    int errors = 0;
    int cnt;

    apb_xfer_sequencer dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_write(req_write), .req_size(req_size), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSTRB(PSTRB), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        HRESET = 1'b1; req_valid = 2'b00; req_addr = '0; req_wdata = '0;
        req_write = 2'b00; req_size = '0; PRDATA = 32'd0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);

        // Single byte write from requester 0, zero wait states
        HRESET = 1'b0; req_valid = 2'b01; req_addr[0] = 32'h8000_1004;
        req_wdata[0] = 32'h1122_3344; req_write[0] = 1'b1; req_size[0] = 3'd0;
        #1;
        chk("w_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00; req_addr[0] = 32'h0; req_wdata[0] = 32'h0;
        chk("w_setup_psel", 32'(PSEL), 32'h2);
        chk("w_setup_penable", 32'(PENABLE), 32'd0);
        chk("w_setup_paddr", PADDR, 32'h8000_1004);
        chk("w_setup_pwdata", PWDATA, 32'h1122_3344);
        chk("w_setup_pstrb", 32'(PSTRB), 32'h1);
        chk("w_setup_pwrite", 32'(PWRITE), 32'h1);
        PREADY = 1'b1;
        tick();
        chk("w_access_penable", 32'(PENABLE), 32'h1);
        chk("w_access_psel", 32'(PSEL), 32'h2);
        tick();
        chk("w_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("w_rsp_err", 32'(rsp_err), 32'd0);
        chk("w_rsp_psel", 32'(PSEL), 32'd0);
        tick();
        chk("w_idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-ACCESS on a requester 1 read
        req_valid = 2'b10; req_addr[1] = 32'h8000_0000; req_write[1] = 1'b0;
        req_size[1] = 3'd2; PREADY = 1'b0;
        #1;
        chk("r1_ready", 32'(req_ready), 32'h2);
        tick(); tick();
        chk("r1_access_penable", 32'(PENABLE), 32'h1);
        HRESET = 1'b1; req_valid = 2'b11;
        #1;
        chk("rst_gate_ready", 32'(req_ready), 32'd0);
        tick();
        chk("midrst_psel", 32'(PSEL), 32'd0);
        chk("midrst_penable", 32'(PENABLE), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Both requesters continuously valid: alternate 0,1,0,1
        HRESET = 1'b0; PREADY = 1'b1;
        req_addr[0] = 32'h8000_0002; req_wdata[0] = 32'hAAAA_5555; req_write[0] = 1'b1; req_size[0] = 3'd1;
        req_addr[1] = 32'h8000_2008; req_write[1] = 1'b0; req_size[1] = 3'd2;
        for (int n = 0; n < 4; n++) begin
            PRDATA = 32'hCAFE_0000 + 32'(n);
            #1;
            chk("rr_ready", 32'(req_ready), (n % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk("rr_psel", 32'(PSEL), (n % 2 == 0) ? 32'h1 : 32'h4);
            chk("rr_pstrb", 32'(PSTRB), (n % 2 == 0) ? 32'hC : 32'h0);
            tick();
            chk("rr_penable", 32'(PENABLE), 32'h1);
            tick();
            chk("rr_rsp_valid", 32'(rsp_valid), (n % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", rsp_rdata, (n % 2 == 0) ? 32'h0 : (32'hCAFE_0000 + 32'(n)));
            chk("rr_resp_no_grant", 32'(req_ready), 32'd0);
            tick();
        end

        // Read with three wait states
        req_valid = 2'b01; req_addr[0] = 32'h8000_3000; req_write[0] = 1'b0; req_size[0] = 3'd2;
        PREADY = 1'b0; PRDATA = 32'h0BAD_0BAD;
        #1;
        chk("ws_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        chk("ws_setup_psel", 32'(PSEL), 32'h8);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("ws_psel", 32'(PSEL), 32'h8);
            chk("ws_penable", 32'(PENABLE), 32'h1);
            chk("ws_paddr", PADDR, 32'h8000_3000);
            chk("ws_pwrite_pstrb", {27'd0, PWRITE, PSTRB}, 32'h0);
        end
        tick();
        chk("ws_last_penable", 32'(PENABLE), 32'h1);
        PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;
        tick();
        chk("ws_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ws_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("ws_err", 32'(rsp_err), 32'd0);
        tick();

        // Decode miss from requester 1
        req_valid = 2'b10; req_addr[1] = 32'h8000_4000;
        #1;
        chk("miss_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        chk("miss_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("miss_err", 32'(rsp_err), 32'h1);
        chk("miss_rdata", rsp_rdata, 32'd0);
        chk("miss_psel", 32'(PSEL), 32'd0);
        chk("miss_paddr_hold", PADDR, 32'h8000_3000);
        tick();

        // Timeout with PREADY held low
        req_valid = 2'b01; req_addr[0] = 32'h8000_0000; req_write[0] = 1'b1; req_size[0] = 3'd2;
        PREADY = 1'b0;
        #1;
        chk("to_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b00;
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (PENABLE) cnt++;
            else break;
        end
        chk("to_access_cycles", 32'(cnt), 32'd16);
        chk("to_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_psel", 32'(PSEL), 32'd0);
        tick();

        // Slave error reported with PREADY
        req_valid = 2'b10; req_addr[1] = 32'h8000_1000; req_write[1] = 1'b0;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0000_1234;
        #1;
        chk("se_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        tick(); tick();
        chk("se_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("se_err", 32'(rsp_err), 32'h1);
        chk("se_rdata", rsp_rdata, 32'h0000_1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
